// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned PcIncr      = 4;
  localparam int unsigned BranchShift = 2;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: sequential PC+4 or branch/CBZ target, modulo 2^ADDR_W.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_imm,
  output logic [ADDR_W-1:0] next_pc
);

  logic taken;

  always_comb begin
    taken   = uncond_branch | (branch & zero);
    next_pc = taken ? pc + (branch_imm << BranchShift) : pc + ADDR_W'(PcIncr);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a variable-latency
// request/response port and holds each word until the datapath accepts it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [ADDR_W-1:0] startpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [10:0]       opcode,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_imm,
  output logic [CNT_W-1:0]  retired_count
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       instr_q;
  logic              instr_valid_q;
  logic              req_q;
  logic [CNT_W-1:0]  retired_q;

  fetch_unit_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc            (pc_q),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .branch_imm    (branch_imm),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q       <= StInit;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
      retired_q     <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          // Masking the low bits keeps every later PC word-aligned.
          pc_q    <= startpc & ~ADDR_W'(PcIncr - 1);
          req_q   <= 1'b1;
          state_q <= StFetch;
        end
        StFetch: begin
          if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b1;
            retired_q     <= retired_q + CNT_W'(1);
            state_q       <= StFetch;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign opcode        = instr_q[31:21];
  assign instr_valid   = instr_valid_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetches
// against a PC/retire-count reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetl;
  logic [63:0] startpc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] pc;
  logic        branch;
  logic        uncond_branch;
  logic        zero;
  logic [63:0] branch_imm;
  logic [31:0] retired_count;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] exp_pc;
  logic [31:0] exp_count;

  fetch_unit #(
    .ADDR_W(64),
    .CNT_W (32)
  ) dut (
    .clk           (clk),
    .resetl        (resetl),
    .startpc       (startpc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .pc            (pc),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .branch_imm    (branch_imm),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [63:0] spc);
    @(negedge clk);
    resetl      = 1'b0;
    startpc     = spc;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_pc", pc, 64'h0);
    check_eq("rst_instr", {32'h0, instr}, 64'h0);
    check_eq("rst_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("rst_req", {63'h0, imem_req}, 64'h0);
    check_eq("rst_count", {32'h0, retired_count}, 64'h0);
    resetl    = 1'b1;
    exp_pc    = {spc[63:2], 2'b00};
    exp_count = 0;
  endtask

  // One full fetch/hold/accept transaction; checks against the model and advances it.
  task automatic fetch_one(input int lat, input int hold, input bit spurious,
                           input bit b, input bit ub, input bit z, input longint imm);
    int          n;
    logic [31:0] w;
    logic [10:0] w_op;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_wait", {63'h0, imem_req}, 64'h1);
    check_eq("imem_addr", imem_addr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_eq("req_held", {63'h0, imem_req}, 64'h1);
      check_eq("no_valid_wait", {63'h0, instr_valid}, 64'h0);
    end
    w           = $urandom;
    w_op        = w[31:21];
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = ~w;
    check_eq("valid", {63'h0, instr_valid}, 64'h1);
    check_eq("instr", {32'h0, instr}, {32'h0, w});
    check_eq("opcode", {53'h0, opcode}, {53'h0, w_op});
    check_eq("hold_pc", pc, exp_pc);
    check_eq("req_off", {63'h0, imem_req}, 64'h0);
    for (int i = 0; i < hold; i++) begin
      imem_rvalid   = spurious && (i == 0);
      branch        = 1'($urandom);
      uncond_branch = 1'($urandom);
      zero          = 1'($urandom);
      branch_imm    = {$urandom, $urandom};
      @(negedge clk);
      imem_rvalid = 1'b0;
      check_eq("stable_instr", {32'h0, instr}, {32'h0, w});
      check_eq("stable_pc", pc, exp_pc);
      check_eq("stable_valid", {63'h0, instr_valid}, 64'h1);
      check_eq("no_req_hold", {63'h0, imem_req}, 64'h0);
    end
    branch        = b;
    uncond_branch = ub;
    zero          = z;
    branch_imm    = 64'(imm);
    instr_ready   = 1'b1;
    @(negedge clk);
    instr_ready   = 1'b0;
    branch        = 1'($urandom);
    uncond_branch = 1'($urandom);
    zero          = 1'($urandom);
    exp_pc    = (ub || (b && z)) ? exp_pc + 64'(imm * 4) : exp_pc + 64'd4;
    exp_count = exp_count + 1;
    check_eq("accept_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("next_pc", pc, exp_pc);
    check_eq("retired", {32'h0, retired_count}, {32'h0, exp_count});
    check_eq("refetch_req", {63'h0, imem_req}, 64'h1);
  endtask

  initial begin
    resetl        = 1'b0;
    startpc       = 64'h0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    instr_ready   = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    zero          = 1'b0;
    branch_imm    = 64'h0;
    exp_pc        = 64'h0;
    exp_count     = 0;

    // Back-to-back sequential fetches from 0x1000.
    do_reset(64'h1000);
    for (int i = 0; i < 3; i++) fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_eq("seq_pc", pc, 64'h100C);
    check_eq("seq_count", {32'h0, retired_count}, 64'h3);

    do_reset(64'h1003);
    check_eq("unaligned_model", exp_pc, 64'h1000);
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Backpressure with a spurious response during hold.
    do_reset(64'h1000);
    fetch_one(3, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    do_reset(64'h2000);
    fetch_one(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, -2);
    check_eq("uncond_tgt", pc, 64'h1FF8);
    do_reset(64'h2000);
    fetch_one(1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 4);
    check_eq("cbz_taken", pc, 64'h2010);
    do_reset(64'h2000);
    fetch_one(0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    check_eq("cbz_not_taken", pc, 64'h2004);

    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_eq("wrap_pc", pc, 64'h0);

    // Reset while a request is outstanding and its response is in flight.
    do_reset(64'h3000);
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_eq("pre_rst_req", {63'h0, imem_req}, 64'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    resetl = 1'b0;
    #1;
    check_eq("async_req_drop", {63'h0, imem_req}, 64'h0);
    @(negedge clk);
    resetl = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_eq("stale_valid", {63'h0, instr_valid}, 64'h0);
    check_eq("stale_instr", {32'h0, instr}, 64'h0);
    check_eq("rst_count_after", {32'h0, retired_count}, 64'h0);
    exp_pc    = 64'h3000;
    exp_count = 0;
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized traffic.
    do_reset({$urandom, $urandom});
    for (int i = 0; i < 40; i++) begin
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                longint'(int'($urandom_range(0, 63)) - 32));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
